vga_timing_gen: RTL and testbench

//  Raster timing generator for the pong display path. Counts pixels and lines,
//  and emits hsync, vsync, de and the pixel coordinates x/y.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 112 +++++++++++
 tb/tb_vga_timing_gen.sv | 102 ++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - phase encoding, default 640x480 timing, width helper
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COORD_W  = 11;

    // Bits needed to hold a count of 0..(active+fp+sync+bp-1).
    function automatic int total_width(input int active, input int fp,
                                       input int sync, input int bp);
        int total;
        total = active + fp + sync + bp;
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position count plus explicit phase
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] count,
    output phase_e       phase,
    output logic         in_active,
    output logic         in_sync,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE - 1);
    localparam logic [W-1:0] FP_END   = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);

    logic [W-1:0] count_q, count_d;
    phase_e       phase_q, phase_d;

    // Next count and next phase; the phase steps on the last count of each region.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (advance) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
            case (phase_q)
                PH_ACTIVE: if (count_q == ACT_END)  phase_d = PH_FRONT;
                PH_FRONT:  if (count_q == FP_END)   phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == SYNC_END) phase_d = PH_BACK;
                PH_BACK:   if (count_q == LAST)     phase_d = PH_ACTIVE;
                default:                            phase_d = PH_ACTIVE;
            endcase
        end
    end

    // Count and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count     = count_q;
    assign phase     = phase_q;
    assign in_active = (phase_q == PH_ACTIVE);
    assign in_sync   = (phase_q == PH_SYNC);
    assign wrap      = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: syncs, de, coordinates, strobes
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int COORD_W    = DEF_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_ce,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               line_start,
    output logic               frame_start
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
        $error("vga_timing_gen: every timing field must be >= 1");
    end
    if (total_width(H_ACTIVE, H_FP, H_SYNC, H_BP) > COORD_W ||
        total_width(V_ACTIVE, V_FP, V_SYNC, V_BP) > COORD_W) begin : g_bad_width
        $error("vga_timing_gen: COORD_W too narrow for H_TOTAL-1 / V_TOTAL-1");
    end

    logic [COORD_W-1:0] h_count, v_count;
    phase_e             h_phase, v_phase;
    logic               h_active, h_in_sync, h_wrap;
    logic               v_active, v_in_sync, v_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(COORD_W)
    ) u_h (
        .clk(clk), .rst(rst), .advance(pix_ce),
        .count(h_count), .phase(h_phase), .in_active(h_active),
        .in_sync(h_in_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(COORD_W)
    ) u_v (
        .clk(clk), .rst(rst), .advance(pix_ce & h_wrap),
        .count(v_count), .phase(v_phase), .in_active(v_active),
        .in_sync(v_in_sync), .wrap(v_wrap)
    );

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;

    // Output set for the current (pre-increment) counters; strobes drop when idle.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            x_d           = h_count;
            y_d           = v_count;
            de_d          = h_active & v_active;
            hsync_d       = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d       = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
            line_start_d  = (h_count == '0);
            frame_start_d = (h_count == '0) && (v_count == '0);
        end
    end

    // Registered outputs; syncs idle at their inactive level out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench against a linear pixel-index model
module tb_vga_timing_gen;

    localparam int HA = 6, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 2, VS = 2, VB = 1;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int CW = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk = 1'b0;
    logic          rst;
    logic          pix_ce;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] x, y;

    int checks = 0;
    int failures = 0;

    int  n;
    int  ex, ey;
    bit  ede, ehs, evs, els, efs;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Predict the output set after the coming clk edge for the given inputs.
    task automatic model_edge(input bit r, input bit c);
        int px, py;
        if (r) begin
            n = 0; ex = 0; ey = 0; ede = 0;
            ehs = ~HPOL; evs = ~VPOL; els = 0; efs = 0;
        end else if (c) begin
            px  = n % HT;
            py  = n / HT;
            ex  = px;
            ey  = py;
            ede = (px < HA) && (py < VA);
            ehs = (px >= HA + HF && px < HA + HF + HS) ? HPOL : ~HPOL;
            evs = (py >= VA + VF && py < VA + VF + VS) ? VPOL : ~VPOL;
            els = (px == 0);
            efs = (n == 0);
            n   = (n + 1) % (HT * VT);
        end else begin
            els = 0;
            efs = 0;
        end
    endtask

    task automatic step(input bit r, input bit c);
        @(negedge clk);
        check("x", int'(x), ex);
        check("y", int'(y), ey);
        check("de", int'(de), int'(ede));
        check("hsync", int'(hsync), int'(ehs));
        check("vsync", int'(vsync), int'(evs));
        check("line_start", int'(line_start), int'(els));
        check("frame_start", int'(frame_start), int'(efs));
        rst    = r;
        pix_ce = c;
        model_edge(r, c);
    endtask

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b1;
        @(posedge clk);
        model_edge(1'b1, 1'b1);
        // Reset held three clocks with pix_ce high.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        // Free-running, one pixel per clk, over two frames and a bit.
        for (int i = 0; i < 2 * HT * VT + 20; i++) step(1'b0, 1'b1);
        // Alternating enable.
        for (int i = 0; i < 2 * HT * VT + 10; i++) step(1'b0, i[0] == 1'b0);
        // Random enable.
        for (int i = 0; i < 1200; i++) step(1'b0, ($urandom % 2) == 0);
        // Random enable with occasional mid-frame resets.
        for (int i = 0; i < 1500; i++) step(($urandom % 97) == 0, ($urandom % 3) != 0);
        step(1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
